br_resolve_queue: RTL

BR_RESOLVE_QUEUE -- requirements
Module: br_resolve_queue

---
 rtl/br_resolve_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/br_resolve_queue.sv
// In-flight branch queue: remembers {index, predicted direction} for each
// predicted branch and emits one predictor-training strobe per resolved branch.

`ifndef BHT_IDX_WIDTH
`define BHT_IDX_WIDTH 10
`endif

module br_resolve_queue #(
  parameter int IDX_W = `BHT_IDX_WIDTH,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     alloc_valid_i,
  input  logic [IDX_W-1:0]         alloc_idx_i,
  input  logic                     alloc_pred_i,
  output logic                     alloc_ready_o,
  input  logic                     resolve_valid_i,
  input  logic                     resolve_taken_i,
  input  logic                     flush_i,
  output logic                     update_en_o,
  output logic [IDX_W-1:0]         update_idx_o,
  output logic                     br_result_o,
  output logic                     mispredict_o,
  output logic [CNT_W-1:0]         mispredict_cnt_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [IDX_W-1:0] idx_mem_q [DEPTH];
  logic             pred_mem_q [DEPTH];

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             update_en_q, update_en_d;
  logic [IDX_W-1:0] update_idx_q, update_idx_d;
  logic             br_result_q, br_result_d;
  logic             mispredict_q, mispredict_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
  logic             underflow_q, underflow_d;

  logic alloc_acc;
  logic res_acc;

  // Readiness looks only at registered occupancy so fetch never sees a
  // combinational path through the resolve port.
  always_comb begin
    alloc_ready_o = (count_q != FULL);
    alloc_acc     = alloc_valid_i && alloc_ready_o && !flush_i;
    res_acc       = resolve_valid_i && (count_q != '0) && !flush_i;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_acc) tail_d = tail_q + PW'(1);
      if (res_acc)   head_d = head_q + PW'(1);
      if (alloc_acc && !res_acc)      count_d = count_q + CW'(1);
      else if (res_acc && !alloc_acc) count_d = count_q - CW'(1);
    end

    update_en_d  = res_acc;
    mispredict_d = res_acc && (pred_mem_q[head_q] != resolve_taken_i);
    update_idx_d = res_acc ? idx_mem_q[head_q] : update_idx_q;
    br_result_d  = res_acc ? resolve_taken_i : br_result_q;
    mp_cnt_d     = (mispredict_d && (mp_cnt_q != '1)) ? mp_cnt_q + CNT_W'(1) : mp_cnt_q;
    underflow_d  = underflow_q | (resolve_valid_i && (count_q == '0) && !flush_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      update_en_q  <= 1'b0;
      update_idx_q <= '0;
      br_result_q  <= 1'b0;
      mispredict_q <= 1'b0;
      mp_cnt_q     <= '0;
      underflow_q  <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      update_en_q  <= update_en_d;
      update_idx_q <= update_idx_d;
      br_result_q  <= br_result_d;
      mispredict_q <= mispredict_d;
      mp_cnt_q     <= mp_cnt_d;
      underflow_q  <= underflow_d;
    end
  end

  // Entry storage is never reset; pointers alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && alloc_acc) begin
      idx_mem_q[tail_q]  <= alloc_idx_i;
      pred_mem_q[tail_q] <= alloc_pred_i;
    end
  end

  assign update_en_o      = update_en_q;
  assign update_idx_o     = update_idx_q;
  assign br_result_o      = br_result_q;
  assign mispredict_o     = mispredict_q;
  assign mispredict_cnt_o = mp_cnt_q;
  assign count_o          = count_q;
  assign underflow_o      = underflow_q;

endmodule
